// File: rtl/ibu_credit_return_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ibu_credit_return_pkg
//  Purpose  : Shared constants, FSM state encoding and header decode helper
//             for the receiver-side input buffer unit.
//  Contents : PORTS, CREDITS, FLITS, FLIT_WIDTH, DEST_MSB, derived widths,
//             state_t (ST_IDLE/ST_SEND), dest_onehot().
//  Revision : 1.0 - initial release
// ============================================================================
package ibu_credit_return_pkg;

   localparam int PORTS      = 5;
   localparam int CREDITS    = 4;
   localparam int FLITS      = 4;
   localparam int FLIT_WIDTH = 32;

   // Destination port field lives in the header flit at [DEST_MSB -: DEST_W].
   localparam int DEST_MSB   = 31;
   localparam int DEST_W     = 3;

   localparam int DEPTH      = CREDITS * FLITS;
   localparam int PKT_W      = $clog2(CREDITS + 1);
   localparam int BEAT_W     = $clog2(FLITS);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Destinations that do not name a real port fall back to port 0 so that
   // a corrupt header still drains instead of wedging the buffer.
   function automatic logic [PORTS-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
      logic [PORTS-1:0] oh;
      oh = '0;
      if (int'(dest) < PORTS) begin
         oh[dest] = 1'b1;
      end else begin
         oh[0] = 1'b1;
      end
      return oh;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ibu_credit_return_if.sv
`default_nettype none
// ============================================================================
//  Module   : ibu_credit_return_if
//  Purpose  : Link/crossbar-facing signal bundle of the input buffer unit.
//  Ports    : flit_in, flit_valid_in, arb_ack_in      (toward the IBU)
//             port_rqs_out, flit_out, credit_out,
//             overflow_err                          (from the IBU)
//             master modport = environment side, slave modport = IBU side.
//  Revision : 1.0 - initial release
// ============================================================================
interface ibu_credit_return_if;
   import ibu_credit_return_pkg::*;

   logic [FLIT_WIDTH-1:0] flit_in;
   logic                  flit_valid_in;
   logic [PORTS-1:0]      arb_ack_in;
   logic [PORTS-1:0]      port_rqs_out;
   logic [FLIT_WIDTH-1:0] flit_out;
   logic                  credit_out;
   logic                  overflow_err;

   modport master (
      output flit_in, flit_valid_in, arb_ack_in,
      input  port_rqs_out, flit_out, credit_out, overflow_err
   );

   modport slave (
      input  flit_in, flit_valid_in, arb_ack_in,
      output port_rqs_out, flit_out, credit_out, overflow_err
   );

endinterface
`default_nettype wire

// File: rtl/ibu_credit_return_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ibu_credit_return_fifo
//  Purpose  : Register-array flit FIFO with wrapping pointers, occupancy
//             count, full flag and asynchronous (combinational) head read.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             i_wr_en/i_wr_data - write request; dropped while full
//             i_rd_en           - pop head; ignored while empty
//             o_rd_data         - entry at the read pointer
//             o_full            - occupancy equals DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module ibu_credit_return_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_wr_en,
   input  wire logic [WIDTH-1:0] i_wr_data,
   input  wire logic             i_rd_en,
   output logic      [WIDTH-1:0] o_rd_data,
   output logic                  o_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign w_wr      = i_wr_en && !o_full;
   assign w_rd      = i_rd_en && (r_count != '0);
   assign o_rd_data = r_mem[r_rd_ptr];

   // Storage carries no reset; contents are only meaningful once written.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/ibu_credit_return.sv
`default_nettype none
// ============================================================================
//  Module   : ibu_credit_return
//  Purpose  : Receiver-side input buffer unit. Buffers fixed-length packets,
//             requests the output port named in the head header once a whole
//             packet is stored, streams it out on acknowledge and returns one
//             link credit per departed packet.
//  Ports    : clk    - system clock
//             reset  - synchronous active-high reset
//             bus    - ibu_credit_return_if.slave (flit input, arbitration
//                      ack, request, flit output, credit, overflow flag)
//  Revision : 1.0 - initial release
// ============================================================================
module ibu_credit_return
   import ibu_credit_return_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             reset,
   ibu_credit_return_if.slave    bus
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [BEAT_W-1:0]     r_beat;
   logic [BEAT_W-1:0]     w_beat_nxt;
   logic [BEAT_W-1:0]     r_in_cnt;
   logic [PKT_W-1:0]      r_pkt_cnt;
   logic                  r_credit;
   logic                  r_overflow;

   logic                  w_full;
   logic                  w_wr_acc;
   logic                  w_pkt_in;
   logic                  w_pkt_out;
   logic                  w_pop;
   logic [PORTS-1:0]      w_rqs;
   logic [FLIT_WIDTH-1:0] w_head;
   logic [DEST_W-1:0]     w_dest;

   ibu_credit_return_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (bus.flit_valid_in),
      .i_wr_data (bus.flit_in),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_full    (w_full)
   );

   // Flits refused by a full buffer must not advance the packet framing.
   assign w_wr_acc = bus.flit_valid_in && !w_full;
   assign w_pkt_in = w_wr_acc && (r_in_cnt == BEAT_W'(FLITS - 1));
   assign w_dest   = w_head[DEST_MSB -: DEST_W];

   assign bus.flit_out     = w_head;
   assign bus.port_rqs_out = w_rqs;
   assign bus.credit_out   = r_credit;
   assign bus.overflow_err = r_overflow;

   // Next-state and per-cycle controls. The head flit is a header whenever
   // the FSM is idle, because whole packets leave back-to-back.
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_rqs       = '0;
      w_pop       = 1'b0;
      w_pkt_out   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_pkt_cnt != '0) begin
               w_rqs = dest_onehot(w_dest);
            end
            if ((bus.arb_ack_in & w_rqs) != '0) begin
               w_pop       = 1'b1;
               w_beat_nxt  = BEAT_W'(FLITS - 1);
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            w_pop      = 1'b1;
            w_beat_nxt = r_beat - BEAT_W'(1);
            if (r_beat == BEAT_W'(1)) begin
               w_pkt_out   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
      end
   end

   // Packet accounting, input framing, credit pulse and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_cnt   <= '0;
         r_pkt_cnt  <= '0;
         r_credit   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_in_cnt <= r_in_cnt + BEAT_W'(1);
         end
         case ({w_pkt_in, w_pkt_out})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + PKT_W'(1);
            2'b01:   r_pkt_cnt <= r_pkt_cnt - PKT_W'(1);
            default: r_pkt_cnt <= r_pkt_cnt;
         endcase
         r_credit <= w_pkt_out;
         if (bus.flit_valid_in && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ibu_credit_return.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ibu_credit_return
//  Purpose  : Scoreboard bench for ibu_credit_return. Directed stimulus
//             pushes cycle-tagged expected flits, request changes and credit
//             pulses; a negedge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ibu_credit_return;
   import ibu_credit_return_pkg::*;

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   checks   = 0;
   int   failures = 0;

   exp_t q_flit[$];
   exp_t q_rq[$];
   int   q_cr[$];

   ibu_credit_return_if bus();

   ibu_credit_return dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] f, input logic [4:0] ack);
      bus.flit_valid_in = v;
      bus.flit_in       = f;
      bus.arb_ack_in    = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 5'b0);
   endtask

   function automatic logic [31:0] mkf(input logic [2:0] d, input logic [7:0] tag, input int i);
      return {d, 13'h0, tag, 8'(i)};
   endfunction

   task automatic exp_rq(input int c, input logic [4:0] v);
      q_rq.push_back('{c, 32'(v)});
   endtask

   task automatic exp_pkt(input int c, input logic [2:0] d, input logic [7:0] tag);
      for (int i = 0; i < 4; i++) q_flit.push_back('{c + i, mkf(d, tag, i)});
   endtask

   // Writes one 4-flit packet; first_ack rides along with the header flit.
   task automatic wr_pkt(input logic [2:0] d, input logic [7:0] tag, input logic [4:0] first_ack);
      for (int i = 0; i < 4; i++) drive(1'b1, mkf(d, tag, i), (i == 0) ? first_ack : 5'b0);
   endtask

   // Acks the head packet now; nxt is the request expected once it has left.
   task automatic pop_pkt(input logic [2:0] d, input logic [7:0] tag, input logic [4:0] ack,
                          input logic [4:0] ign, input logic [4:0] nxt);
      int c;
      c = cyc;
      exp_pkt(c, d, tag);
      exp_rq(c + 1, 5'b0);
      q_cr.push_back(c + 4);
      if (nxt != 5'b0) exp_rq(c + 4, nxt);
      drive(1'b0, 32'h0, ack);
      for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, ign);
   endtask

   // Monitor / scoreboard
   initial begin
      logic [4:0] prev_rqs;
      exp_t       e;
      prev_rqs = 5'b0;
      forever begin
         @(negedge clk);
         if (q_flit.size() > 0 && q_flit[0].cyc == cyc) begin
            e = q_flit.pop_front();
            chk("flit_out", bus.flit_out, e.val);
         end
         while (q_rq.size() > 0 && q_rq[0].cyc < cyc) begin
            e = q_rq.pop_front();
            checks++; failures++;
            $display("FAIL rq_missed @cyc %0d: expected %h at cyc %0d, got %h", cyc, e.val, e.cyc, bus.port_rqs_out);
         end
         if (bus.port_rqs_out !== prev_rqs) begin
            if (q_rq.size() == 0) begin
               checks++; failures++;
               $display("FAIL rq_unexpected @cyc %0d: got %h expected %h", cyc, bus.port_rqs_out, prev_rqs);
            end else begin
               e = q_rq.pop_front();
               chk("rq_cycle", cyc, e.cyc);
               chk("rq_value", 32'(bus.port_rqs_out), e.val);
            end
            prev_rqs = bus.port_rqs_out;
         end
         while (q_cr.size() > 0 && q_cr[0] < cyc) begin
            checks++; failures++;
            $display("FAIL credit_missed @cyc %0d: got none expected pulse at cyc %0d", cyc, q_cr.pop_front());
         end
         if (bus.credit_out !== 1'b0) begin
            if (q_cr.size() > 0 && q_cr[0] == cyc) begin
               chk("credit_pulse", 32'(bus.credit_out), 32'd1);
               void'(q_cr.pop_front());
            end else begin
               checks++; failures++;
               $display("FAIL credit_unexpected @cyc %0d: got %b expected 0", cyc, bus.credit_out);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      bus.flit_valid_in = 1'b0;
      bus.flit_in       = '0;
      bus.arb_ack_in    = '0;
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      chk("rst_rqs",      32'(bus.port_rqs_out), 32'd0);
      chk("rst_credit",   32'(bus.credit_out),   32'd0);
      chk("rst_overflow", 32'(bus.overflow_err), 32'd0);
      chk("rst_pkt_cnt",  32'(dut.r_pkt_cnt),    32'd0);

      // Single packet dest=2, ack two cycles after the request; acks
      // repeated during SEND must be ignored.
      t = cyc;
      exp_rq(t + 4, 5'b00100);
      wr_pkt(3'd2, 8'h11, 5'b0);
      idle(2);
      pop_pkt(3'd2, 8'h11, 5'b00100, 5'b00100, 5'b0);
      idle(3);

      // Fill with four packets, then a 17th flit, a stray ack, then drain.
      t = cyc;
      exp_rq(t + 4, 5'b00010);
      wr_pkt(3'd1, 8'h21, 5'b0);
      wr_pkt(3'd3, 8'h22, 5'b0);
      wr_pkt(3'd4, 8'h23, 5'b0);
      wr_pkt(3'd0, 8'h24, 5'b0);
      chk("full_no_overflow", 32'(bus.overflow_err), 32'd0);
      chk("full_pkt_cnt",     32'(dut.r_pkt_cnt),    32'd4);
      drive(1'b1, 32'hDEAD_BEEF, 5'b0);
      chk("overflow_set",     32'(bus.overflow_err), 32'd1);
      chk("overflow_count",   32'(dut.u_fifo.r_count), 32'd16);
      drive(1'b0, 32'h0, 5'b01000);
      chk("stray_ack_state",  32'(dut.r_state),      32'(ST_IDLE));
      chk("stray_ack_pkts",   32'(dut.r_pkt_cnt),    32'd4);
      pop_pkt(3'd1, 8'h21, 5'b00010, 5'b0, 5'b01000);
      pop_pkt(3'd3, 8'h22, 5'b01000, 5'b0, 5'b10000);
      pop_pkt(3'd4, 8'h23, 5'b10000, 5'b0, 5'b00001);
      pop_pkt(3'd0, 8'h24, 5'b00001, 5'b0, 5'b0);
      idle(2);

      // Write a packet while the previous one streams out.
      t = cyc;
      exp_rq(t + 4, 5'b00100);
      wr_pkt(3'd2, 8'h31, 5'b0);
      exp_pkt(t + 4, 3'd2, 8'h31);
      exp_rq(t + 5, 5'b0);
      q_cr.push_back(t + 8);
      exp_rq(t + 8, 5'b10000);
      wr_pkt(3'd4, 8'h32, 5'b00100);
      chk("overlap_pkt_cnt", 32'(dut.r_pkt_cnt), 32'd1);
      pop_pkt(3'd4, 8'h32, 5'b10000, 5'b0, 5'b0);
      idle(2);

      // Out-of-range destination maps to port 0.
      t = cyc;
      exp_rq(t + 4, 5'b00001);
      wr_pkt(3'd6, 8'h41, 5'b0);
      pop_pkt(3'd6, 8'h41, 5'b00001, 5'b0, 5'b0);
      idle(2);

      // Reset during the second SEND beat abandons the packet.
      t = cyc;
      exp_rq(t + 4, 5'b10000);
      wr_pkt(3'd4, 8'h51, 5'b0);
      q_flit.push_back('{t + 4, mkf(3'd4, 8'h51, 0)});
      q_flit.push_back('{t + 5, mkf(3'd4, 8'h51, 1)});
      exp_rq(t + 5, 5'b0);
      drive(1'b0, 32'h0, 5'b10000);
      reset = 1'b1;
      drive(1'b0, 32'h0, 5'b0);
      reset = 1'b0;
      chk("midrst_rqs",      32'(bus.port_rqs_out), 32'd0);
      chk("midrst_credit",   32'(bus.credit_out),   32'd0);
      chk("midrst_overflow", 32'(bus.overflow_err), 32'd0);
      chk("midrst_pkt_cnt",  32'(dut.r_pkt_cnt),    32'd0);
      chk("midrst_state",    32'(dut.r_state),      32'(ST_IDLE));
      t = cyc;
      exp_rq(t + 4, 5'b01000);
      wr_pkt(3'd3, 8'h61, 5'b0);
      pop_pkt(3'd3, 8'h61, 5'b01000, 5'b0, 5'b0);
      idle(4);

      chk("flits_drained",  32'(q_flit.size()), 32'd0);
      chk("rq_drained",     32'(q_rq.size()),   32'd0);
      chk("credit_drained", 32'(q_cr.size()),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
